// File: rtl/aes_pkg.sv
// Shared AES-128 constants and round-controller state encoding.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;
  localparam int RK_IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SUB   = 3'd1,
    MIX   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the state register and ARK XOR,
// drives the external SubBytes/ShiftRows and 1-cycle mixcolumns paths.
module aes_round_ctrl #(
  parameter int NR       = aes_pkg::AES_NR,
  parameter int RK_IDX_W = aes_pkg::RK_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [aes_pkg::AES_BLK_W-1:0] in_data,
  output logic [RK_IDX_W-1:0]           rk_idx,
  input  logic [aes_pkg::AES_BLK_W-1:0] rk_in,
  output logic [aes_pkg::AES_BLK_W-1:0] sbsr_in,
  input  logic [aes_pkg::AES_BLK_W-1:0] sbsr_out,
  output logic [aes_pkg::AES_BLK_W-1:0] mc_din,
  input  logic [aes_pkg::AES_BLK_W-1:0] mc_dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [aes_pkg::AES_BLK_W-1:0] out_data,
  output logic                          busy
);

  import aes_pkg::*;

  localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RK_ONE  = RK_IDX_W'(1);

  aes_state_e               fsm_q;
  logic [RK_IDX_W-1:0]      round_q;
  logic [RK_IDX_W-1:0]      round_d;
  logic [AES_BLK_W-1:0]     state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic [RK_IDX_W-1:0]      rk_idx_q;

  assign round_d = round_q + RK_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= in_data ^ rk_in;
            round_q    <= RK_ONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (NR == 1) begin
              fsm_q    <= FINAL;
              rk_idx_q <= RK_LAST;
            end else begin
              fsm_q    <= SUB;
              rk_idx_q <= RK_ONE;
            end
          end
        end
        // State is held here so mc_din is identical in the following MIX.
        SUB: fsm_q <= MIX;
        MIX: begin
          state_q <= mc_dout ^ rk_in;
          round_q <= round_d;
          if (round_d == RK_LAST) begin
            fsm_q    <= FINAL;
            rk_idx_q <= RK_LAST;
          end else begin
            fsm_q    <= SUB;
            rk_idx_q <= round_d;
          end
        end
        FINAL: begin
          state_q     <= sbsr_out ^ rk_in;
          fsm_q       <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            round_q     <= '0;
            rk_idx_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign sbsr_in   = state_q;
  assign mc_din    = sbsr_out;
  assign out_data  = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: reference AES datapath, key store and
// a plain AES-128 model used to predict every ciphertext.
module tb_aes_round_ctrl;

  typedef logic [0:10][127:0] rks_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic [127:0] sbsr_in;
  logic [127:0] sbsr_out;
  logic [127:0] mc_din;
  logic [127:0] mc_dout;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  rks_t         rks;
  logic [127:0] mc_x2_q;
  int           n_chk;
  int           n_fail;
  int           cyc;

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .sbsr_in   (sbsr_in),
    .sbsr_out  (sbsr_out),
    .mc_din    (mc_din),
    .mc_dout   (mc_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x, r, s;
    x = gmul(a, a);
    r = x;
    for (int i = 0; i < 6; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
      ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(gb(v, i));
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gb(v, 4*((c+r)%4)+r);
    return o;
  endfunction

  function automatic logic [127:0] xtime_all(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = xtime(gb(v, i));
    return o;
  endfunction

  // b_r = 2a_r ^ 3a_{r+1} ^ a_{r+2} ^ a_{r+3}, with 2a terms supplied in x2.
  function automatic logic [127:0] mc_combine(input logic [127:0] x2,
                                              input logic [127:0] a);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gb(x2, 4*c+r) ^ gb(x2, 4*c+(r+1)%4)
          ^ gb(a, 4*c+(r+1)%4) ^ gb(a, 4*c+(r+2)%4) ^ gb(a, 4*c+(r+3)%4);
    return o;
  endfunction

  function automatic rks_t key_exp(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rks_t        o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                           input logic [127:0] key);
    rks_t         k;
    logic [127:0] s;
    k = key_exp(key);
    s = pt ^ k[0];
    for (int r = 1; r < 10; r++) begin
      s = shift_rows(sub_bytes(s));
      s = mc_combine(xtime_all(s), s) ^ k[r];
    end
    return shift_rows(sub_bytes(s)) ^ k[10];
  endfunction

  // External environment: key store, SubBytes/ShiftRows, 1-cycle mixcolumns.
  assign rk_in = (rk_idx <= 4'd10) ? rks[rk_idx] : '0;
  always_comb sbsr_out = shift_rows(sub_bytes(sbsr_in));
  always @(posedge clk) mc_x2_q <= xtime_all(mc_din);
  always_comb mc_dout = mc_combine(mc_x2_q, mc_din);

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input int hold);
    logic [127:0] exp;
    logic [127:0] mc_sub;
    int           k;
    bit           seen;
    exp = aes_ref(pt, key);
    rks = key_exp(key);
    mc_sub = '0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b1);
    in_data  = pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    k = 0;
    seen = 0;
    while (!seen && k <= 40) begin
      chk("rk_idx", rk_idx, (k >= 18) ? 10 : k / 2 + 1);
      if (k < 18 && k % 2 == 0) mc_sub = mc_din;
      if (k < 18 && k % 2 == 1) chk("mc_din_stable", mc_din, mc_sub);
      if (out_valid) begin
        seen = 1;
        chk("latency", k, 19);
      end else begin
        chk("busy", {in_ready, busy}, 2'b01);
        @(negedge clk);
        k++;
      end
    end
    if (!seen) chk("out_valid_timeout", 1'b0, 1'b1);
    chk("cipher", out_data, exp);
    repeat (hold) begin
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_data", out_data, exp);
      chk("bp_flags", {out_valid, in_ready, busy}, 3'b101);
      chk("bp_rk", rk_idx, 10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_flags", {out_valid, in_ready, busy}, 3'b010);
    chk("drain_rk", rk_idx, 0);
  endtask

  task automatic run_b2b();
    logic [127:0] exp [3];
    int           acc [3];
    logic [127:0] pt, key;
    int           n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      pt     = {$urandom, $urandom, $urandom, $urandom};
      key    = {$urandom, $urandom, $urandom, $urandom};
      exp[b] = aes_ref(pt, key);
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("b2b_ready_timeout", 1'b0, 1'b1);
      acc[b]  = cyc;
      in_data = pt;
      rks     = key_exp(key);
      @(negedge clk);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (!out_valid && n < 40) begin
        chk("b2b_ignore", in_ready, 1'b0);
        @(negedge clk);
        n++;
      end
      if (n >= 40) chk("b2b_valid_timeout", 1'b0, 1'b1);
      chk("b2b_cipher", out_data, exp[b]);
      if (b == 2) in_valid = 1'b0;
      if (b > 0) chk("b2b_spacing", acc[b] - acc[b-1], 21);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_idle", {in_ready, busy, out_valid}, 3'b100);
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rks       = key_exp(KEY_B);
    @(negedge clk);
    chk("rst_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_rk", rk_idx, 0);
    chk("rst_data", out_data, '0);
    rst = 1'b0;

    run_block(PT_B, KEY_B, 7);
    chk("appb_ct", out_data, CT_B);
    run_block(PT_C, KEY_C, 0);
    chk("c1_ct", out_data, CT_C);

    // Abort a block in flight and check it leaves no trace.
    rks = key_exp(KEY_C);
    @(negedge clk);
    in_data  = PT_C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("abort_data", out_data, '0);
    chk("abort_rk", rk_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    run_block(PT_B, KEY_B, 1);
    chk("abort_appb_ct", out_data, CT_B);

    for (int i = 0; i < 4; i++)
      run_block({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 3)));

    run_b2b();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
